// File: rtl/alu_execute_stage_if.sv
// Operand/result bundle between decode + register bank and the ALU execute stage.
interface alu_execute_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  Start;
  logic [3:0]            Opcode;
  logic [ADDR_WIDTH-1:0] Dest_In;
  logic [DATA_WIDTH-1:0] Operand_1;
  logic [DATA_WIDTH-1:0] Operand_2;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] ALU_Result;
  logic [ADDR_WIDTH-1:0] Dest_Out;
  logic                  Write_Enable;
  logic [3:0]            Flags;

  // Issuer side: drives requests, observes results.
  modport master (
    output Start, Opcode, Dest_In, Operand_1, Operand_2,
    input  Busy, Done, ALU_Result, Dest_Out, Write_Enable, Flags
  );

  // Execute stage side.
  modport slave (
    input  Start, Opcode, Dest_In, Operand_1, Operand_2,
    output Busy, Done, ALU_Result, Dest_Out, Write_Enable, Flags
  );
endinterface

// File: rtl/alu_execute_stage.sv
// ALU execute stage: latches operands on Start, produces a registered result,
// write-back destination and NZCV flags. MUL is an iterative shift-add.
module alu_execute_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic               Clock,
  input logic               Reset,
  alu_execute_stage_if.slave bus
);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            opcode_reg, opcode_next;
  logic [ADDR_WIDTH-1:0] dest_reg, dest_next;
  logic [ADDR_WIDTH-1:0] dest_out_reg, dest_out_next;
  // During MUL, op1 is the shifting multiplicand and op2 the shifting multiplier.
  logic [DATA_WIDTH-1:0] op1_reg, op1_next;
  logic [DATA_WIDTH-1:0] op2_reg, op2_next;
  logic [DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic [5:0]            count_reg, count_next;
  logic [3:0]            flags_reg, flags_next;   // {N,Z,C,V}
  logic                  done_reg, done_next;
  logic                  we_reg, we_next;

  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   lsl_full;
  logic [DATA_WIDTH:0]   lsr_full;
  logic [DATA_WIDTH-1:0] sub_res;
  logic [DATA_WIDTH-1:0] mul_sum;
  logic [7:0]            shamt;

  logic [DATA_WIDTH-1:0] exec_res;
  logic                  exec_c;
  logic                  exec_v;
  logic                  exec_we;
  logic                  exec_defined;

  // The extra bit on the shifters catches the last bit shifted out, and an
  // amount beyond the width naturally yields a zero result and zero carry.
  assign add_full = {1'b0, op1_reg} + {1'b0, op2_reg};
  assign sub_res  = op1_reg - op2_reg;
  assign shamt    = op2_reg[7:0];
  assign lsl_full = {1'b0, op1_reg} << shamt;
  assign lsr_full = {op1_reg, 1'b0} >> shamt;
  assign mul_sum  = acc_reg + (op2_reg[0] ? op1_reg : '0);

  // Single-cycle ALU: result, carry/overflow and write-back decision per opcode.
  always_comb begin
    exec_res     = result_reg;
    exec_c       = flags_reg[1];
    exec_v       = flags_reg[0];
    exec_we      = 1'b1;
    exec_defined = 1'b1;
    case (opcode_reg)
      OP_ADD: begin
        exec_res = add_full[MSB:0];
        exec_c   = add_full[DATA_WIDTH];
        exec_v   = (op1_reg[MSB] == op2_reg[MSB]) && (add_full[MSB] != op1_reg[MSB]);
      end
      OP_SUB, OP_CMP: begin
        exec_res = sub_res;
        exec_c   = (op1_reg >= op2_reg);
        exec_v   = (op1_reg[MSB] != op2_reg[MSB]) && (sub_res[MSB] != op1_reg[MSB]);
        exec_we  = (opcode_reg == OP_SUB);
      end
      OP_AND: exec_res = op1_reg & op2_reg;
      OP_ORR: exec_res = op1_reg | op2_reg;
      OP_EOR: exec_res = op1_reg ^ op2_reg;
      OP_MOV: exec_res = op2_reg;
      OP_LSL: begin
        exec_res = lsl_full[MSB:0];
        if (shamt != 8'd0) exec_c = lsl_full[DATA_WIDTH];
      end
      OP_LSR: begin
        exec_res = lsr_full[DATA_WIDTH:1];
        if (shamt != 8'd0) exec_c = lsr_full[0];
      end
      default: begin
        exec_we      = 1'b0;
        exec_defined = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic for the IDLE/EXEC/MUL sequencer.
  always_comb begin
    state_next    = state_reg;
    opcode_next   = opcode_reg;
    dest_next     = dest_reg;
    dest_out_next = dest_out_reg;
    op1_next      = op1_reg;
    op2_next      = op2_reg;
    acc_next      = acc_reg;
    result_next   = result_reg;
    count_next    = count_reg;
    flags_next    = flags_reg;
    done_next     = 1'b0;
    we_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          opcode_next = bus.Opcode;
          dest_next   = bus.Dest_In;
          op1_next    = bus.Operand_1;
          op2_next    = bus.Operand_2;
          acc_next    = '0;
          count_next  = '0;
          state_next  = (bus.Opcode == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        done_next     = 1'b1;
        dest_out_next = dest_reg;
        we_next       = exec_we;
        if (exec_we) result_next = exec_res;
        if (exec_defined) flags_next = {exec_res[MSB], (exec_res == '0), exec_c, exec_v};
        state_next = IDLE;
      end
      MUL: begin
        acc_next   = mul_sum;
        op1_next   = op1_reg << 1;
        op2_next   = op2_reg >> 1;
        count_next = count_reg + 6'd1;
        if (count_reg == 6'(DATA_WIDTH - 1)) begin
          result_next   = mul_sum;
          flags_next    = {mul_sum[MSB], (mul_sum == '0), flags_reg[1:0]};
          dest_out_next = dest_reg;
          done_next     = 1'b1;
          we_next       = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      dest_reg     <= '0;
      dest_out_reg <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      acc_reg      <= '0;
      result_reg   <= '0;
      count_reg    <= '0;
      flags_reg    <= '0;
      done_reg     <= 1'b0;
      we_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      dest_reg     <= dest_next;
      dest_out_reg <= dest_out_next;
      op1_reg      <= op1_next;
      op2_reg      <= op2_next;
      acc_reg      <= acc_next;
      result_reg   <= result_next;
      count_reg    <= count_next;
      flags_reg    <= flags_next;
      done_reg     <= done_next;
      we_reg       <= we_next;
    end
  end

  assign bus.Busy         = (state_reg != IDLE);
  assign bus.Done         = done_reg;
  assign bus.ALU_Result   = result_reg;
  assign bus.Dest_Out     = dest_out_reg;
  assign bus.Write_Enable = we_reg;
  assign bus.Flags        = flags_reg;
endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed self-checking bench for alu_execute_stage.
module tb_alu_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_execute_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  alu_execute_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request for exactly one edge; returns at the negedge after the latch edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] b);
    bus.Start     = 1'b1;
    bus.Opcode    = op;
    bus.Dest_In   = d;
    bus.Operand_1 = a;
    bus.Operand_2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (bus.Done) break;
    end
  endtask

  // Single-cycle op: Done must appear at the second edge after Start.
  task automatic run(input string tag, input logic [3:0] op, input logic [3:0] d,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic [3:0] exp_flags,
                     input logic exp_we);
    int n;
    issue(op, d, a, b);
    wait_done(5, n);
    chk({tag, "_latency"}, 32'(n), 32'd1);
    chk({tag, "_res"}, bus.ALU_Result, exp_res);
    chk({tag, "_flags"}, 32'(bus.Flags), 32'(exp_flags));
    chk({tag, "_we"}, 32'(bus.Write_Enable), 32'(exp_we));
    if (exp_we) chk({tag, "_dest"}, 32'(bus.Dest_Out), 32'(d));
    $display("txn %s op=%0d a=%h b=%h res=%h flags=%b we=%b", tag, op, a, b,
             bus.ALU_Result, bus.Flags, bus.Write_Enable);
  endtask

  initial begin
    int n;
    int dones;
    int busy_bad;
    bus.Start     = 1'b0;
    bus.Opcode    = '0;
    bus.Dest_In   = '0;
    bus.Operand_1 = '0;
    bus.Operand_2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",  32'(bus.Busy), 32'd0);
    chk("rst_done",  32'(bus.Done), 32'd0);
    chk("rst_res",   bus.ALU_Result, 32'd0);
    chk("rst_flags", 32'(bus.Flags), 32'd0);
    chk("rst_we",    32'(bus.Write_Enable), 32'd0);

    // ADD with explicit latency / busy / single-pulse checks
    issue(4'd0, 4'd3, 32'd7, 32'd8);
    chk("add_busy", 32'(bus.Busy), 32'd1);
    chk("add_done_early", 32'(bus.Done), 32'd0);
    @(negedge clk);
    chk("add_done", 32'(bus.Done), 32'd1);
    chk("add_res", bus.ALU_Result, 32'd15);
    chk("add_dest", 32'(bus.Dest_Out), 32'd3);
    chk("add_we", 32'(bus.Write_Enable), 32'd1);
    chk("add_flags", 32'(bus.Flags), 32'd0);
    @(negedge clk);
    chk("add_done_pulse", 32'(bus.Done), 32'd0);
    chk("add_we_pulse", 32'(bus.Write_Enable), 32'd0);
    $display("txn add res=%h", bus.ALU_Result);

    run("sub", 4'd1, 4'd4, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b1000, 1'b1);
    run("cmp", 4'd9, 4'd5, 32'h10, 32'h10, 32'hFFFF_FFFE, 4'b0110, 1'b0);

    // MUL with an ignored Start pulse at cycle 5
    issue(4'd8, 4'd6, 32'h0000_FFFF, 32'h0001_0001);
    n = 0;
    busy_bad = 0;
    while (n < 40) begin
      if (n == 5) begin
        bus.Start = 1'b1; bus.Opcode = 4'd0; bus.Dest_In = 4'd9;
        bus.Operand_1 = 32'd1; bus.Operand_2 = 32'd1;
      end else begin
        bus.Start = 1'b0;
      end
      if (!bus.Busy) busy_bad++;
      @(negedge clk);
      n++;
      if (bus.Done) break;
    end
    bus.Start = 1'b0;
    chk("mul_latency", 32'(n), 32'd32);
    chk("mul_busy_span", 32'(busy_bad), 32'd0);
    chk("mul_res", bus.ALU_Result, 32'hFFFF_FFFF);
    chk("mul_flags", 32'(bus.Flags), 32'b1010);
    chk("mul_we", 32'(bus.Write_Enable), 32'd1);
    chk("mul_dest", 32'(bus.Dest_Out), 32'd6);
    $display("txn mul res=%h flags=%b cycles=%0d", bus.ALU_Result, bus.Flags, n);
    @(negedge clk);
    chk("mul_ignored_start_busy", 32'(bus.Busy), 32'd0);
    chk("mul_ignored_start_done", 32'(bus.Done), 32'd0);

    run("add_v",   4'd0, 4'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b1);
    run("add_c",   4'd0, 4'd1, 32'hFFFF_FFFF, 32'd1, 32'h0,         4'b0110, 1'b1);
    run("and",     4'd2, 4'd2, 32'hF0F0, 32'hFF00, 32'hF000,         4'b0010, 1'b1);
    run("eor",     4'd4, 4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b1010, 1'b1);
    run("mov",     4'd5, 4'd2, 32'h1234, 32'h0, 32'h0,               4'b0110, 1'b1);
    run("sub_b",   4'd1, 4'd2, 32'd1, 32'd2, 32'hFFFF_FFFF,          4'b1000, 1'b1);
    run("lsl1",    4'd6, 4'd7, 32'h8000_0001, 32'd1,  32'h2,         4'b0010, 1'b1);
    run("lsl32",   4'd6, 4'd7, 32'h8000_0001, 32'd32, 32'h0,         4'b0110, 1'b1);
    run("lsr0",    4'd7, 4'd7, 32'h8000_0001, 32'd0,  32'h8000_0001, 4'b1010, 1'b1);
    run("lsr40",   4'd7, 4'd7, 32'h8000_0001, 32'd40, 32'h0,         4'b0100, 1'b1);
    run("lsr32",   4'd7, 4'd7, 32'h8000_0000, 32'd32, 32'h0,         4'b0110, 1'b1);
    run("lsr5",    4'd7, 4'd7, 32'h0000_00F0, 32'd5,  32'h7,         4'b0010, 1'b1);
    run("undef",   4'd12, 4'd8, 32'd5, 32'd5, 32'h7,                 4'b0010, 1'b0);

    // Reset 10 cycles into a MUL aborts it with no Done
    issue(4'd8, 4'd9, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  32'(bus.Busy), 32'd0);
    chk("abort_done",  32'(bus.Done), 32'd0);
    chk("abort_res",   bus.ALU_Result, 32'd0);
    chk("abort_dest",  32'(bus.Dest_Out), 32'd0);
    chk("abort_flags", 32'(bus.Flags), 32'd0);
    chk("abort_we",    32'(bus.Write_Enable), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    $display("txn abort dones=%0d", dones);
    run("add_after_rst", 4'd0, 4'd2, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b1);

    // Back-to-back: ADD issued in the Done cycle of an ORR
    issue(4'd3, 4'd7, 32'h0F0, 32'h00F);
    wait_done(5, n);
    chk("b2b_orr_latency", 32'(n), 32'd1);
    chk("b2b_orr_res", bus.ALU_Result, 32'hFF);
    $display("txn orr res=%h", bus.ALU_Result);
    issue(4'd0, 4'd8, 32'h10, 32'h20);
    chk("b2b_gap_done", 32'(bus.Done), 32'd0);
    @(negedge clk);
    chk("b2b_add_done", 32'(bus.Done), 32'd1);
    chk("b2b_add_res", bus.ALU_Result, 32'h30);
    chk("b2b_add_dest", 32'(bus.Dest_Out), 32'd8);
    $display("txn b2b add res=%h", bus.ALU_Result);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
